// File: rtl/id_stage_if.sv
// IF/ID -> ID -> ID/EX pipeline bus for the decode stage.
// Upstream offers an instruction with in_valid; it is consumed on a clock edge where in_valid && in_ready, and out_* is the registered ID/EX payload qualified by out_valid.
interface id_stage_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;

    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic        out_load;

    modport master (
        output in_valid, in_instr, in_pc,
        input  in_ready,
        input  out_valid, out_pc, out_instr, out_rs_data, out_rt_data,
        input  out_imm, out_dst, out_wen, out_load
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        output in_ready,
        output out_valid, out_pc, out_instr, out_rs_data, out_rt_data,
        output out_imm, out_dst, out_wen, out_load
    );
endinterface

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: decodes fields, forwards from EX/MEM(/WB), stalls on load-use hazards.
// Macro ID_BYPASS_WB_EN: when defined, WB results are bypassed; otherwise a WB hazard costs one bubble.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus,
    output logic [4:0]  reg1_addr,
    output logic [4:0]  reg2_addr,
    input  logic [31:0] reg1_data,
    input  logic [31:0] reg2_data,
    input  logic [31:0] ex_result,
    input  logic [4:0]  mem_dst,
    input  logic        mem_wen,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_dst,
    input  logic        wb_wen,
    input  logic [31:0] wb_data,
    input  logic        hold,
    input  logic        flush
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [5:0]  op;
    logic [4:0]  dec_dst;
    logic        dec_wen;
    logic        dec_load;
    logic [31:0] dec_imm;
    logic        no_write;

    logic [1:0][4:0]  src;
    logic [1:0][31:0] rf_data;
    logic [1:0][31:0] opnd;
    logic [1:0]       used;
    logic [1:0]       lu_hit;
    logic [1:0]       wb_hit;
    logic             load_use;
    logic             wb_stall;

    assign op        = bus.in_instr[31:26];
    assign reg1_addr = bus.in_instr[25:21];
    assign reg2_addr = bus.in_instr[20:16];

    always_comb begin
        dec_dst = reg2_addr;
        if (op == OP_RTYPE)
            dec_dst = bus.in_instr[15:11];
        else if (op == OP_JAL)
            dec_dst = 5'd31;
    end

    assign no_write = (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    assign dec_wen  = !no_write && (dec_dst != 5'd0);
    assign dec_load = (op == OP_LW);
    assign dec_imm  = ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI))
                    ? {16'h0000, bus.in_instr[15:0]}
                    : {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};

    assign src[0]     = reg1_addr;
    assign src[1]     = reg2_addr;
    assign rf_data[0] = reg1_data;
    assign rf_data[1] = reg2_data;
    assign used[0]    = !((op == OP_J) || (op == OP_JAL));
    assign used[1]    = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

    // Newest producer wins: the instruction in our own output register is in EX now.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wb_hit[i] = wb_wen && (wb_dst == src[i]) && (src[i] != 5'd0);
            lu_hit[i] = used[i] && bus.out_valid && bus.out_load &&
                        (bus.out_dst != 5'd0) && (bus.out_dst == src[i]);
            if (src[i] == 5'd0)
                opnd[i] = 32'd0;
            else if (bus.out_valid && bus.out_wen && !bus.out_load && (bus.out_dst == src[i]))
                opnd[i] = ex_result;
            else if (mem_wen && (mem_dst == src[i]))
                opnd[i] = mem_result;
`ifdef ID_BYPASS_WB_EN
            else if (wb_hit[i])
                opnd[i] = wb_data;
`endif
            else
                opnd[i] = rf_data[i];
        end
    end

    assign load_use = |lu_hit;

`ifdef ID_BYPASS_WB_EN
    assign wb_stall = 1'b0;
`else
    // Without the bypass, wait one cycle for the regfile write to land.
    logic wb_data_unused;
    assign wb_data_unused = ^wb_data;
    assign wb_stall = |(wb_hit & used);
`endif

    assign bus.in_ready = !hold && !load_use && !wb_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_instr   <= '0;
            bus.out_rs_data <= '0;
            bus.out_rt_data <= '0;
            bus.out_imm     <= '0;
            bus.out_dst     <= '0;
            bus.out_wen     <= 1'b0;
            bus.out_load    <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
            bus.out_wen   <= 1'b0;
        end else if (!hold) begin
            if (bus.in_valid && bus.in_ready) begin
                bus.out_valid   <= 1'b1;
                bus.out_pc      <= bus.in_pc;
                bus.out_instr   <= bus.in_instr;
                bus.out_rs_data <= opnd[0];
                bus.out_rt_data <= opnd[1];
                bus.out_imm     <= dec_imm;
                bus.out_dst     <= dec_dst;
                bus.out_wen     <= dec_wen;
                bus.out_load    <= dec_load;
            end else begin
                bus.out_valid <= 1'b0;
                bus.out_wen   <= 1'b0;
            end
        end
    end
endmodule
